// File: rtl/piece_move_sched.sv
// Falling-piece sequencer: latches move requests, runs one collision check at a
// time, commits legal moves, and walks the lock/spawn handshake on landing.
module piece_move_sched #(
    parameter logic [3:0] SPAWN_X     = 4'd6,
    parameter logic [3:0] SPAWN_BLOCK = 4'b0000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       gravityTick,
    input  logic       leftReq,
    input  logic       rightReq,
    input  logic       rotReq,
    input  logic [3:0] nextBlock,
    input  logic       canMove,
    input  logic       lockAck,
    output logic       enDown,
    output logic       enLeft,
    output logic       enRight,
    output logic       enRot,
    output logic       enFit,
    output logic [3:0] chkBlock,
    output logic [3:0] XPOS,
    output logic [4:0] YPOS,
    output logic [3:0] currentBlock,
    output logic       lockReq,
    output logic       gameOver
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_EVAL, S_LOCK, S_SPAWN, S_OVER
    } state_t;

    typedef enum logic [2:0] {
        OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROT, OP_FIT
    } op_t;

    function automatic logic [3:0] rot_blk(input logic [3:0] b);
        logic [3:0] r;
        case (b)
            4'd0:    r = 4'd1;
            4'd1:    r = 4'd0;
            4'd3:    r = 4'd4;
            4'd4:    r = 4'd3;
            4'd5:    r = 4'd6;
            4'd6:    r = 4'd7;
            4'd7:    r = 4'd8;
            4'd8:    r = 4'd5;
            4'd9:    r = 4'd10;
            4'd10:   r = 4'd11;
            4'd11:   r = 4'd12;
            4'd12:   r = 4'd9;
            4'd13:   r = 4'd14;
            4'd14:   r = 4'd13;
            default: r = b;
        endcase
        return r;
    endfunction

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [3:0] pend_q, pend_d;   // {rot, right, left, down}
    logic [3:0] pend_clr;
    logic [3:0] xpos_q, xpos_d;
    logic [4:0] ypos_q, ypos_d;
    logic [3:0] blk_q, blk_d;
    logic [3:0] rot_cur;
    op_t        sel_op;
    logic       any_pend;

    assign rot_cur  = rot_blk(blk_q);
    assign any_pend = |pend_q;

    always_comb begin
        sel_op = OP_ROT;
        if (pend_q[0])      sel_op = OP_DOWN;
        else if (pend_q[1]) sel_op = OP_LEFT;
        else if (pend_q[2]) sel_op = OP_RIGHT;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        blk_d    = blk_q;
        pend_clr = 4'b0000;
        enDown   = 1'b0;
        enLeft   = 1'b0;
        enRight  = 1'b0;
        enRot    = 1'b0;
        enFit    = 1'b0;
        chkBlock = blk_q;

        case (state_q)
            S_IDLE: begin
                if (any_pend) begin
                    op_d    = sel_op;
                    state_d = S_WAIT;
                    case (sel_op)
                        OP_DOWN:  enDown  = 1'b1;
                        OP_LEFT:  enLeft  = 1'b1;
                        OP_RIGHT: enRight = 1'b1;
                        default: begin
                            enRot    = 1'b1;
                            chkBlock = rot_cur;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (op_q == OP_ROT) chkBlock = rot_cur;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (op_q == OP_ROT) chkBlock = rot_cur;
                state_d = S_IDLE;
                case (op_q)
                    OP_DOWN: begin
                        pend_clr[0] = 1'b1;
                        if (canMove) ypos_d  = ypos_q + 5'd1;
                        else         state_d = S_LOCK;
                    end
                    OP_LEFT: begin
                        pend_clr[1] = 1'b1;
                        if (canMove) xpos_d = xpos_q - 4'd1;
                    end
                    OP_RIGHT: begin
                        pend_clr[2] = 1'b1;
                        if (canMove) xpos_d = xpos_q + 4'd1;
                    end
                    OP_ROT: begin
                        pend_clr[3] = 1'b1;
                        if (canMove) blk_d = rot_cur;
                    end
                    default: begin
                        if (!canMove) state_d = S_OVER;
                    end
                endcase
            end
            S_LOCK: begin
                if (lockAck) state_d = S_SPAWN;
            end
            S_SPAWN: begin
                // Piece state is loaded here so the fit check and the committed
                // block see the same nextBlock value.
                enFit    = 1'b1;
                chkBlock = nextBlock;
                xpos_d   = SPAWN_X;
                ypos_d   = 5'd0;
                blk_d    = nextBlock;
                op_d     = OP_FIT;
                state_d  = S_WAIT;
            end
            default: state_d = S_OVER;
        endcase

        // A pulse landing in the clearing cycle re-arms its flag.
        pend_d = (pend_q & ~pend_clr) | {rotReq, rightReq, leftReq, gravityTick};
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            op_q    <= OP_DOWN;
            pend_q  <= 4'b0000;
            xpos_q  <= SPAWN_X;
            ypos_q  <= 5'd0;
            blk_q   <= SPAWN_BLOCK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pend_q  <= pend_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            blk_q   <= blk_d;
        end
    end

    assign XPOS         = xpos_q;
    assign YPOS         = ypos_q;
    assign currentBlock = blk_q;
    assign lockReq      = (state_q == S_LOCK);
    assign gameOver     = (state_q == S_OVER);

endmodule

// File: tb/tb_piece_move_sched.sv
// Directed plus randomized checks of piece_move_sched against a transaction-level
// model of piece position, pending requests and the lock/spawn flow.
module tb_piece_move_sched;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       gravityTick = 1'b0, leftReq = 1'b0, rightReq = 1'b0, rotReq = 1'b0;
    logic [3:0] nextBlock = 4'd0;
    logic       canMove = 1'b0;
    logic       lockAck = 1'b0;
    logic       enDown, enLeft, enRight, enRot, enFit;
    logic [3:0] chkBlock, XPOS, currentBlock;
    logic [4:0] YPOS;
    logic       lockReq, gameOver;
    logic [4:0] en_vec;

    piece_move_sched dut (
        .Clock(Clock), .Resetn(Resetn),
        .gravityTick(gravityTick), .leftReq(leftReq), .rightReq(rightReq), .rotReq(rotReq),
        .nextBlock(nextBlock), .canMove(canMove), .lockAck(lockAck),
        .enDown(enDown), .enLeft(enLeft), .enRight(enRight), .enRot(enRot), .enFit(enFit),
        .chkBlock(chkBlock), .XPOS(XPOS), .YPOS(YPOS), .currentBlock(currentBlock),
        .lockReq(lockReq), .gameOver(gameOver)
    );

    assign en_vec = {enFit, enRot, enRight, enLeft, enDown};

    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    // Reference model
    int m_x, m_y, m_blk;
    bit pd, pl, pr, pt, m_over;
    int rot_tab [16] = '{1, 0, 2, 4, 3, 6, 7, 8, 5, 10, 11, 12, 9, 14, 13, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge Clock);
    endtask

    task automatic model_reset();
        m_x = 6; m_y = 0; m_blk = 0;
        pd = 0; pl = 0; pr = 0; pt = 0; m_over = 0;
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, "_x"}, XPOS, m_x);
        chk({tag, "_y"}, YPOS, m_y);
        chk({tag, "_blk"}, currentBlock, m_blk);
    endtask

    task automatic pulse(input bit g, input bit l, input bit r, input bit t);
        gravityTick = g; leftReq = l; rightReq = r; rotReq = t;
        pd |= g; pl |= l; pr |= r; pt |= t;
        nclk();
        gravityTick = 0; leftReq = 0; rightReq = 0; rotReq = 0;
    endtask

    // Called at a negedge where the DUT is idle with a request pending.
    task automatic service(input bit res, input bit repulse, output bit locked);
        int op;
        locked = 0;
        if (pd) op = 0; else if (pl) op = 1; else if (pr) op = 2; else op = 3;
        chk("en_sel", en_vec, 32'(1) << op);
        chk("chk_blk", chkBlock, (op == 3) ? rot_tab[m_blk] : m_blk);
        nclk();
        chk("wait_quiet", en_vec, 0);
        canMove = res;
        nclk();
        chk("eval_quiet", en_vec, 0);
        if (repulse) begin
            gravityTick = (op == 0); leftReq = (op == 1); rightReq = (op == 2); rotReq = (op == 3);
        end
        nclk();
        gravityTick = 0; leftReq = 0; rightReq = 0; rotReq = 0;
        canMove = 1'($urandom_range(0, 1));
        case (op)
            0: begin pd = 0; if (res) m_y = (m_y + 1) % 32; else locked = 1; end
            1: begin pl = 0; if (res) m_x = (m_x + 15) % 16; end
            2: begin pr = 0; if (res) m_x = (m_x + 1) % 16; end
            default: begin pt = 0; if (res) m_blk = rot_tab[m_blk]; end
        endcase
        if (repulse) begin
            pd |= (op == 0); pl |= (op == 1); pr |= (op == 2); pt |= (op == 3);
        end
        chk_pos("commit");
        chk("lock_entry", lockReq, locked);
    endtask

    // Called at a negedge with the DUT in LOCK.
    task automatic do_lock(input int hold, input int nb, input bit fit);
        for (int i = 0; i < hold; i++) begin
            chk("lock_hold", lockReq, 1);
            chk("lock_quiet", en_vec, 0);
            nclk();
        end
        chk("lock_before_ack", lockReq, 1);
        lockAck = 1; nextBlock = 4'(nb);
        nclk();
        lockAck = 0;
        chk("spawn_lockreq", lockReq, 0);
        chk("spawn_enfit", en_vec, 5'b10000);
        chk("spawn_chk", chkBlock, nb);
        nclk();
        canMove = fit;
        m_x = 6; m_y = 0; m_blk = nb;
        chk("fit_wait_quiet", en_vec, 0);
        chk_pos("spawn");
        nclk();
        chk("fit_eval_quiet", en_vec, 0);
        nclk();
        canMove = 1'($urandom_range(0, 1));
        if (!fit) m_over = 1;
        chk("gameover", gameOver, m_over);
    endtask

    initial begin
        bit lk;
        bit g, l, r, t;
        int guard;
        model_reset();

        // Reset state
        nclk();
        chk("rst_en", en_vec, 0);
        chk_pos("rst");
        chk("rst_lockreq", lockReq, 0);
        chk("rst_gameover", gameOver, 0);
        Resetn = 1;
        nclk();

        // lockAck outside LOCK does nothing
        lockAck = 1; nclk(); nclk(); lockAck = 0;
        chk("stray_ack_lockreq", lockReq, 0);
        chk("stray_ack_en", en_vec, 0);
        chk_pos("stray_ack");

        // T1: right move, 3-cycle latency; a repeat pulse during EVAL is kept
        pulse(0, 0, 1, 0);
        chk("t1_no_early", XPOS, 6);
        service(1, 1, lk);
        chk("t1_x7", XPOS, 7);
        service(1, 0, lk);
        chk("t1_idle_en", en_vec, 0);

        // T2: down and left together, down first
        pulse(1, 1, 0, 0);
        service(1, 0, lk);
        service(1, 0, lk);
        chk("t2_idle_en", en_vec, 0);

        // Descend to row 17, land, and latch a left pulse during LOCK
        while (m_y < 17) begin
            pulse(1, 0, 0, 0);
            service(1, 0, lk);
        end
        pulse(1, 0, 0, 0);
        service(0, 0, lk);
        chk("t4_locked", lk, 1);
        pulse(0, 1, 0, 0);
        do_lock(4, 8, 1);
        service(1, 0, lk);

        // T3: rotate J4 (8): refused then accepted
        pulse(0, 0, 0, 1);
        service(0, 0, lk);
        chk("t3_stays8", currentBlock, 8);
        pulse(0, 0, 0, 1);
        service(1, 0, lk);
        chk("t3_now5", currentBlock, 5);

        // T4: land and hold lockAck low five cycles, spawn block 9
        pulse(1, 0, 0, 0);
        service(0, 0, lk);
        do_lock(5, 9, 1);
        chk("t4_blk9", currentBlock, 9);

        // T6: async reset while a left move is in WAIT
        pulse(0, 0, 1, 0);
        service(1, 0, lk);
        pulse(0, 1, 0, 0);
        nclk();
        canMove = 1;
        #2 Resetn = 0;
        #1;
        model_reset();
        chk("t6_async_en", en_vec, 0);
        chk_pos("t6_async");
        nclk();
        Resetn = 1;
        nclk(); nclk(); nclk();
        chk_pos("t6_stale");
        chk("t6_idle_en", en_vec, 0);

        // Randomized request bursts
        for (int it = 0; it < 60; it++) begin
            {g, l, r, t} = 4'($urandom_range(1, 15));
            pulse(g, l, r, t);
            guard = 0;
            while ((pd | pl | pr | pt) && guard < 20) begin
                guard++;
                service(1'($urandom_range(0, 1)), 0, lk);
                if (lk) do_lock($urandom_range(0, 3), $urandom_range(0, 15), 1);
            end
            chk("rand_drained", {pd, pl, pr, pt}, 0);
        end

        // T5: spawn refused -> game over, frozen until reset
        pulse(1, 0, 0, 0);
        service(0, 0, lk);
        do_lock(1, 3, 0);
        pulse(1, 1, 1, 1);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_en", en_vec, 0);
            chk("t5_sticky", gameOver, 1);
            chk("t5_no_lock", lockReq, 0);
            nclk();
        end
        chk_pos("t5_frozen");
        Resetn = 0;
        #1;
        model_reset();
        chk("t5_reset_clears", gameOver, 0);
        chk_pos("t5_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_move_sched.md
Name: piece_move_sched

Overview:
- Sequencer for the falling tetromino. Owns the piece state XPOS, YPOS and currentBlock, and arbitrates move requests: gravity, left, right and rotate.
- Drives one registered collision checker at a time (checkDown/checkLeft/checkRight/checkRotate/checkFit) and commits the move if the checker permits it.
- On landing, hands off to the board writer via a lock handshake, then spawns the next piece.

Parameters:
SPAWN_X, 6, XPOS loaded on spawn
SPAWN_BLOCK, 4'b0000, currentBlock after reset

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
gravityTick  in  1  one-cycle pulse: request move down
leftReq  in  1  one-cycle pulse: move left
rightReq  in  1  one-cycle pulse: move right
rotReq  in  1  one-cycle pulse: rotate clockwise
nextBlock  in  4  block code for next spawn
canMove  in  1  shared checker result, valid 1 cycle after enable
lockAck  in  1  board writer done
enDown, enLeft, enRight, enRot, enFit  out  1 each  checker enables, one-hot or zero
chkBlock  out  4  block code presented to checkers
XPOS  out  4  committed piece column
YPOS  out  5  committed piece row
currentBlock  out  4  committed block code
lockReq  out  1  request board write of current piece
gameOver  out  1  sticky

Behaviour:
- Reset (async, Resetn=0): XPOS=SPAWN_X, YPOS=0, currentBlock=SPAWN_BLOCK, all enables=0, lockReq=0, gameOver=0, pending flags cleared, state=IDLE.
- Requests: each pulse sets a pending flag (pD, pL, pR, pT). A flag clears only when its request is serviced. A pulse arriving in the cycle its own flag clears re-sets it, so it is not lost. Pulses seen in LOCK/SPAWN/OVER are latched and kept.
- Priority in IDLE: pD > pL > pR > pT. One request per service.
- chkBlock = currentBlock, except for rotate, where chkBlock = rot(currentBlock).
- rot(): 0<->1; 2->2; 3<->4; 5->6->7->8->5; 9->10->11->12->9; 13<->14; 15->15.
- IDLE: if any flag is set, assert the selected enable for exactly 1 cycle, go to WAIT.
- WAIT: the checker registers its result. Go to EVAL.
- EVAL: sample canMove.
  - If canMove=1: commit one of down YPOS+1, left XPOS-1, right XPOS+1, rotate currentBlock=chkBlock. Clear the flag, go to IDLE.
  - If canMove=0 on left/right/rotate: clear the flag, no state change, go to IDLE.
  - If canMove=0 on down: clear pD, go to LOCK.
- Latency: request pulse to committed position = 3 cycles when idle.
- LOCK: lockReq held at 1 until lockAck=1. The cycle after lockAck: lockReq=0, go to SPAWN. lockAck outside LOCK is ignored.
- SPAWN: load XPOS=SPAWN_X, YPOS=0, currentBlock=nextBlock. Pulse enFit with chkBlock=nextBlock, then run WAIT/EVAL.
  - canMove=1: go to IDLE.
  - canMove=0: gameOver=1, go to OVER.
- OVER: absorbing state. All enables 0, outputs frozen; only Resetn exits.
- Arithmetic: XPOS/YPOS are unsigned. No wrap protection is added here; boundary legality comes entirely from the checker. A canMove=1 on left at XPOS=0 is a checker bug and would wrap.
- At most one enable is high in any cycle. No enable is asserted in WAIT, EVAL or LOCK.
- Reset mid-operation: immediate return to reset values. Any in-flight checker result is discarded.

Test Plan:
1. Reset, then rightReq with canMove=1 in EVAL -> enRight high 1 cycle, XPOS 6->7 three cycles after the pulse; YPOS and currentBlock unchanged.
2. gravityTick and leftReq in the same cycle, canMove=1 both -> down serviced first (YPOS 0->1), then left (XPOS 6->5). Total 6 cycles; enables never overlap.
3. currentBlock=8 (J4), rotReq, canMove=1 -> chkBlock=5 during enRot, currentBlock=5. Repeat with canMove=0 -> currentBlock stays 8.
4. gravityTick with canMove=0 at YPOS=17 -> lockReq=1. Hold lockAck=0 for 5 cycles, lockReq stays 1. lockAck=1 -> spawn with nextBlock=9, XPOS=6, YPOS=0, enFit pulse.
5. Spawn fit check returns canMove=0 -> gameOver=1 and stays 1. Further requests produce no enables until Resetn.
6. Assert Resetn=0 during WAIT of a left move -> outputs return to reset values asynchronously. The stale canMove after reset does not alter XPOS.
